fetch_stage: RTL



---
 rtl/fetch_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC and next-PC selection, and runs a
// single-outstanding request/response handshake with instruction memory.
module fetch_stage #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stallf,
   input  logic                     pcsrce,
   input  logic [ADDRESS_WIDTH-1:0] pctargete,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_rvalid,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic [DATA_WIDTH-1:0]    instrf,
   output logic [ADDRESS_WIDTH-1:0] pcf,
   output logic [ADDRESS_WIDTH-1:0] pcplus4f,
   output logic                     validf
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] READY = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]               state;
   logic [1:0]               state_nxt;
   logic [ADDRESS_WIDTH-1:0] pc_nxt;
   logic [DATA_WIDTH-1:0]    ibuf;
   logic [DATA_WIDTH-1:0]    ibuf_nxt;
   logic [ADDRESS_WIDTH-1:0] target;

   assign target    = {pctargete[ADDRESS_WIDTH-1:2], 2'b00};
   assign pcplus4f  = pcf + ADDRESS_WIDTH'(4);
   assign imem_addr = pcf;
   assign imem_req  = !rst && (state == FETCH);

   always_comb begin
      validf = 1'b0;
      instrf = NOP_INSTR;
      if (!rst) begin
         unique case (state)
            FETCH: begin
               if (!pcsrce && imem_rvalid) begin
                  validf = 1'b1;
                  instrf = imem_rdata;
               end
            end
            READY: begin
               if (!pcsrce) begin
                  validf = 1'b1;
                  instrf = ibuf;
               end
            end
            default: ;
         endcase
      end
   end

   // Redirect always takes priority over stall; a squashed response is
   // drained in DRAIN so it can never be mistaken for the new target.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pcf;
      ibuf_nxt  = ibuf;
      unique case (state)
         FETCH: begin
            if (pcsrce) begin
               pc_nxt    = target;
               state_nxt = imem_rvalid ? FETCH : DRAIN;
            end else if (imem_rvalid && !stallf) begin
               pc_nxt = pcplus4f;
            end else if (imem_rvalid) begin
               ibuf_nxt  = imem_rdata;
               state_nxt = READY;
            end
         end
         READY: begin
            if (pcsrce) begin
               pc_nxt    = target;
               state_nxt = FETCH;
            end else if (!stallf) begin
               pc_nxt    = pcplus4f;
               state_nxt = FETCH;
            end
         end
         DRAIN: begin
            if (pcsrce) pc_nxt = target;
            if (imem_rvalid) state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcf   <= RESET_PC;
         state <= FETCH;
         ibuf  <= NOP_INSTR;
      end else begin
         pcf   <= pc_nxt;
         state <= state_nxt;
         ibuf  <= ibuf_nxt;
      end
   end

endmodule
